multicycle_controller: RTL and testbench

Multicycle main control unit for the RV32I core, the successor to the single-cycle opcode decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles. It drives a shared-memory datapath through a request/ready handshake and adds the jump and upper-immediate opcodes. Illegal opcodes raise a sticky trap, and a retired-instruction counter is provided.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_out_decode.sv | 86 ++++++++
 rtl/multicycle_controller.sv | 115 +++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main control unit:
// opcodes, FSM states, datapath select codes and the output bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_IMM   = 7'd19;
  localparam logic [6:0] OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_JAL   = 7'd111;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEMADR,
    MEMRD, MEMWB, MEMWR, EXEC_R,
    EXEC_I, ALUWB, BEQ, JAL,
    JALR, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational output map: FSM state + mem_ready -> control bundle.
// In: state, mem_ready. Out: ctrl (all datapath controls, 0 unless set).
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t    state,
  input  logic      mem_ready,
  output ctrl_out_t ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        // IR and PC only load on the completing cycle
        if (mem_ready) begin
          ctrl.ir_write   = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.result_src = RES_ALU;
        end
      end
      DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      MEMADR, JALR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      BEQ: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
      end
      JAL: begin
        // PC <- target held in ALU result reg; ALU makes old PC + 4
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      AUIPC: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control FSM with sticky trap and retire counter.
// In: clk, rst_n, opcode, mem_ready. Out: datapath controls, illegal, retired.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  state_t           dispatch;
  ctrl_out_t        ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    dispatch = TRAP;
    unique case (1'b1)
      opcode == OP_LOAD,
      opcode == OP_STORE:            dispatch = MEMADR;
      opcode == OP_R:                dispatch = EXEC_R;
      opcode == OP_IMM:              dispatch = EXEC_I;
      opcode == OP_BR:               dispatch = BEQ;
      EN_JUMP && opcode == OP_JAL:   dispatch = JAL;
      EN_JUMP && opcode == OP_JALR:  dispatch = JALR;
      EN_UPPER && opcode == OP_LUI:  dispatch = LUI;
      EN_UPPER && opcode == OP_AUIPC: dispatch = AUIPC;
      default:                       dispatch = TRAP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST:    state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: state_d = dispatch;
      MEMADR: state_d = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC_R, EXEC_I, JAL, LUI, AUIPC:
              state_d = ALUWB;
      ALUWB, BEQ:
              state_d = FETCH;
      JALR:   state_d = JAL;
      TRAP:   state_d = TRAP;
      default: state_d = state_q;
    endcase
  end

  // Only these states end an instruction; RST->FETCH is not a retire
  always_comb begin
    illegal_d = illegal_q | (state_d == TRAP);
    retired_d = retired_q;
    if (state_d == FETCH &&
        (state_q == MEMWB || state_q == MEMWR ||
         state_q == ALUWB || state_q == BEQ))
      retired_d = retired_q + CNT_ONE;
  end

  ctrl_out_decode u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three configurations on shared inputs,
// per-cycle output vectors from an instruction-level phase model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          sel = 0;
  int unsigned mret = 0;

  logic [15:0] ov[3];
  logic [31:0] rv[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 2) ? 4 : 32;
    localparam bit EN = (g != 1);
    logic         req, we, adr, irw, pcw, br, rw, ill;
    logic [1:0]   a, b, op, rs;
    logic [W-1:0] ret;
    multicycle_controller #(
      .CNT_W(W), .EN_JUMP(EN), .EN_UPPER(EN)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode),
      .mem_ready(mem_ready), .mem_req(req), .mem_we(we),
      .adr_src(adr), .ir_write(irw), .pc_write(pcw),
      .branch(br), .reg_write(rw), .alu_src_a(a),
      .alu_src_b(b), .alu_op(op), .result_src(rs),
      .illegal(ill), .retired(ret)
    );
    assign ov[g] = {req, we, adr, irw, pcw, br, rw, a, b, op, rs, ill};
    assign rv[g] = 32'(ret);
  end

  // {req,we,adr,irw,pcw,br,rw}, src_a, src_b, alu_op, result_src, illegal
  localparam logic [15:0] ZERO    = 16'h0000;
  localparam logic [15:0] F_STALL = {7'b1000000, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] F_DONE  = {7'b1001100, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0};
  localparam logic [15:0] DEC     = {7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] MADR    = {7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] MRD     = {7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] MWB     = {7'b0000001, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0};
  localparam logic [15:0] MWR     = {7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] EXR     = {7'b0000000, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0};
  localparam logic [15:0] EXI     = {7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0, 1'b0};
  localparam logic [15:0] AWB     = {7'b0000001, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] BEQV    = {7'b0000010, 2'd2, 2'd0, 2'd1, 2'd0, 1'b0};
  localparam logic [15:0] JALV    = {7'b0000100, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] JALRV   = {7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] LUIV    = {7'b0000000, 2'd3, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] AUIV    = {7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [15:0] TRAPV   = 16'h0001;

  logic [15:0] eq[$];
  bit          rq[$];

  task automatic push(logic [15:0] v, bit r);
    eq.push_back(v);
    rq.push_back(r);
  endtask

  function automatic bit rnd();
    return bit'($urandom % 2);
  endfunction

  // Phase sequence of one instruction, derived from its class
  task automatic build(input logic [6:0] op, input int fw, mw, ntrap,
                       input bit en, output bit retires);
    eq.delete();
    rq.delete();
    for (int i = 0; i < fw; i++) push(F_STALL, 1'b0);
    push(F_DONE, 1'b1);
    push(DEC, rnd());
    retires = 1'b1;
    case (int'(op))
      3: begin
        push(MADR, rnd());
        for (int i = 0; i < mw; i++) push(MRD, 1'b0);
        push(MRD, 1'b1);
        push(MWB, rnd());
      end
      35: begin
        push(MADR, rnd());
        for (int i = 0; i < mw; i++) push(MWR, 1'b0);
        push(MWR, 1'b1);
      end
      51: begin push(EXR, rnd()); push(AWB, rnd()); end
      19: begin push(EXI, rnd()); push(AWB, rnd()); end
      99: push(BEQV, rnd());
      111: if (en) begin push(JALV, rnd()); push(AWB, rnd()); end
           else retires = 1'b0;
      103: if (en) begin
             push(JALRV, rnd()); push(JALV, rnd()); push(AWB, rnd());
           end else retires = 1'b0;
      55: if (en) begin push(LUIV, rnd()); push(AWB, rnd()); end
          else retires = 1'b0;
      23: if (en) begin push(AUIV, rnd()); push(AWB, rnd()); end
          else retires = 1'b0;
      default: retires = 1'b0;
    endcase
    if (!retires)
      for (int i = 0; i < ntrap; i++) push(TRAPV, rnd());
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rmask();
    return (sel == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  task automatic chk_ret(string nm);
    chk(nm, rv[sel] & rmask(), mret & rmask());
  endtask

  task automatic cyc(bit r, logic [15:0] e, string nm);
    mem_ready = r;
    #1;
    chk(nm, 32'(ov[sel]), 32'(e));
    @(negedge clk);
  endtask

  // Asserts reset between clock edges so the clear must be asynchronous
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(ov[sel]), 32'(ZERO));
    mret = 0;
    chk_ret("async_rst_ret");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(rnd(), ZERO, "rst_state");
  endtask

  task automatic run(input logic [6:0] op, input int fw, mw, ntrap,
                     input string nm);
    bit ret;
    opcode = op;
    build(op, fw, mw, ntrap, sel != 1, ret);
    foreach (eq[i]) cyc(rq[i], eq[i], $sformatf("%s[%0d]", nm, i));
    if (ret) mret++;
    chk_ret({nm, "_ret"});
  endtask

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    int         ntrap;
    int         sel;
    bit         exp_ill;
  } vec_t;

  vec_t tbl[$];

  logic [6:0] legal[9] = '{7'd3, 7'd19, 7'd23, 7'd35, 7'd51,
                           7'd55, 7'd99, 7'd103, 7'd111};
  logic [6:0] bad[4] = '{7'h00, 7'h7F, 7'h0F, 7'h73};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      '{7'd51,  0, 0, 0,  0, 1'b0},
      '{7'd3,   2, 3, 0,  0, 1'b0},
      '{7'd35,  0, 0, 0,  0, 1'b0},
      '{7'd35,  1, 2, 0,  0, 1'b0},
      '{7'd19,  0, 0, 0,  0, 1'b0},
      '{7'd99,  0, 0, 0,  0, 1'b0},
      '{7'd111, 0, 0, 0,  0, 1'b0},
      '{7'd103, 0, 0, 0,  0, 1'b0},
      '{7'd55,  0, 0, 0,  0, 1'b0},
      '{7'd23,  1, 0, 0,  0, 1'b0},
      '{7'h7F,  0, 0, 3,  0, 1'b1},
      '{7'd103, 0, 0, 20, 1, 1'b1},
      '{7'd55,  1, 0, 2,  1, 1'b1},
      '{7'd51,  0, 0, 0,  1, 1'b0}
    };

    @(negedge clk);
    sel = 0;
    do_reset();
    foreach (tbl[i]) begin
      if (i > 0 && (tbl[i].sel != sel || tbl[i-1].exp_ill)) begin
        sel = tbl[i].sel;
        do_reset();
      end
      run(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].ntrap,
          $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_illegal", i), 32'(ov[sel][0]),
          32'(tbl[i].exp_ill));
    end

    // Reset during a stalled store must drop the request at once
    sel = 0;
    do_reset();
    run(7'd51, 0, 0, 0, "pre_abandon");
    opcode = 7'd35;
    cyc(1'b1, F_DONE, "ab_fetch");
    cyc(rnd(), DEC, "ab_dec");
    cyc(rnd(), MADR, "ab_madr");
    cyc(1'b0, MWR, "ab_mwr_stall");
    mem_ready = 1'b0;
    do_reset();
    run(7'd99, 0, 0, 0, "post_abandon");

    // 17 branches on the 4-bit counter wrap 16 back to 0, then 1
    sel = 2;
    do_reset();
    for (int i = 0; i < 17; i++) run(7'd99, 0, 0, 0, $sformatf("wrap%0d", i));
    chk("wrap_final", rv[2], 32'd1);

    sel = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      bit         is_bad;
      logic [6:0] op;
      is_bad = ($urandom % 10) == 0;
      op = is_bad ? bad[$urandom % 4] : legal[$urandom % 9];
      run(op, int'($urandom % 3), int'($urandom % 3), 2,
          $sformatf("rnd%0d_op%0d", i, op));
      if (is_bad) begin
        chk($sformatf("rnd%0d_illegal", i), 32'(ov[0][0]), 32'd1);
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
